gcd_operand_loader: RTL and testbench
=====================================

GCD_OPERAND_LOADER -- requirements
Module: gcd_operand_loader

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1: consecutive synchronized samples at one level needed to accept a key level change (range 1..255).
REQ-002 SHALL have port clk, input, 1: single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port sw, input, 4: operand nibble from slide switches; quasi-static, not synchronized.
REQ-005 SHALL have port key, input, 2: raw push-buttons, active-low, asynchronous; key[0] = load nibble, key[1] = submit.
REQ-006 SHALL have port out_ready, input, 1: downstream GCD core can accept an operand pair.
REQ-007 SHALL have port op_valid, output, 1: op_a/op_b hold a complete pair on offer.
REQ-008 SHALL have port op_a, output, 8: first operand.
REQ-009 SHALL have port op_b, output, 8: second operand.
REQ-010 SHALL have port nib_cnt, output, 3: nibbles loaded so far (0..4), for LED status.

Function
REQ-011 Each key bit SHALL pass a 2-flop synchronizer, then a debouncer changing its accepted level only after DB_CYCLES consecutive equal synchronized samples.
REQ-012 Each key SHALL yield a 1-cycle press pulse on an accepted 1->0 transition; releases produce no pulse; one press = one pulse, however long held.
REQ-013 Latency: raw key first sampled low at edge k (held stable) -> its action is visible on outputs after edge k+2+DB_CYCLES.
REQ-014 FSM states: COLLECT, FULL, OFFER.
REQ-015 COLLECT: key[0] pulse captures sw at the pulse edge into nibble slot nib_cnt and increments nib_cnt; slot order 0->op_a[7:4], 1->op_a[3:0], 2->op_b[7:4], 3->op_b[3:0].
REQ-016 COLLECT: when the 4th nibble is captured (nib_cnt becomes 4), go to FULL on the same edge.
REQ-017 COLLECT: key[1] pulse with nib_cnt<4 SHALL be ignored (no state, count or operand change).
REQ-018 FULL: key[0] pulses ignored; key[1] pulse -> OFFER, op_valid=1 from next cycle.
REQ-019 OFFER: op_valid, op_a, op_b held stable until a cycle with op_valid=1 and out_ready=1; on that edge -> COLLECT, nib_cnt=0, op_valid=0; op_a/op_b retain values.
REQ-020 OFFER: key[0] and key[1] pulses ignored; out_ready asserted before OFFER has no effect and is not remembered.
REQ-021 Simultaneous key[0] and key[1] pulses in the same cycle: each evaluated against the current state per REQ-015..020 (in COLLECT key[0] acts, key[1] ignored; in FULL key[1] acts).
REQ-022 A new pair SHALL overwrite op_a/op_b nibble by nibble from slot 0; stale nibbles remain visible until overwritten.
REQ-023 sw SHALL be sampled only on a capture edge; changes elsewhere have no effect.

Reset
REQ-024 While rst_n=0 at a rising edge: state=COLLECT, nib_cnt=0, op_valid=0, op_a=0, op_b=0, synchronizers and debouncer accepted levels=1 (released), debounce counters=0, no pulses.
REQ-025 Reset mid-operation (any state, including OFFER) SHALL abandon the pair with no handshake; a key held low across reset deassertion SHALL NOT produce a pulse until released and pressed again.

Structure
REQ-026 Shared package gcd_pkg SHALL hold the FSM state encoding (COLLECT/FULL/OFFER), NIBBLES_PER_PAIR=4 and operand width 8, shared with the GCD core.
REQ-027 Sub-module key_debounce (synchronizer + debouncer + press-pulse, parameter DB_CYCLES) SHALL be instantiated once per key bit.

Verification
REQ-028 Reset, then presses with sw=0000,1111,0001,1001, then key[1], out_ready=1 -> op_a=0x0F, op_b=0x19, op_valid high exactly 1 cycle, nib_cnt 1,2,3,4 then 0.
REQ-029 key[1] after 2 nibbles -> no change; 2 more nibbles + key[1] -> op_valid=1.
REQ-030 out_ready=0 for 20 cycles in OFFER with key[0] presses and sw toggling -> op_valid, op_a, op_b unchanged; out_ready=1 -> one handshake, nib_cnt=0.
REQ-031 DB_CYCLES=4: key[0] low 3 cycles -> no capture; low 6 cycles -> exactly one capture at edge k+6; 1-cycle glitches ignored.
REQ-032 rst_n=0 for 1 cycle during OFFER with key[0] held low -> all outputs 0, no capture until key[0] released and re-pressed.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD operand loader and the GCD core it feeds.
package gcd_pkg;

  localparam int NIBBLES_PER_PAIR = 4;
  localparam int OPERAND_W        = 8;
  localparam int PAIR_W           = 2 * OPERAND_W;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    OFFER   = 2'd2
  } gcd_state_e;

  // Slot 0 is the most significant nibble of op_a, slot 3 the least significant of op_b.
  function automatic logic [PAIR_W-1:0] insert_nibble(
    input logic [PAIR_W-1:0] pair,
    input logic [1:0]        slot,
    input logic [3:0]        nib
  );
    logic [PAIR_W-1:0] res;
    res = pair;
    case (slot)
      2'd0:    res[15:12] = nib;
      2'd1:    res[11:8]  = nib;
      2'd2:    res[7:4]   = nib;
      default: res[3:0]   = nib;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: 2-flop synchronizer, level debouncer and single-cycle press pulse.
module key_debounce #(
  parameter int DB_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] fill_q, fill_d;
  logic       level_q, level_d;
  logic [7:0] cnt_q, cnt_d;
  logic       armed_q, armed_d;
  logic       press_q, press_d;

  // fill_q marks when sync2_q carries a real post-reset sample rather than its reset value;
  // armed_q stays low until the key has been seen released, so a key held through reset never fires.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    fill_d  = {fill_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    press_d = 1'b0;
    if (fill_q[1]) begin
      if (sync2_q) begin
        armed_d = 1'b1;
      end
      if (sync2_q == level_q) begin
        cnt_d = 8'd0;
      end else if (cnt_q == DB_LAST) begin
        cnt_d   = 8'd0;
        level_d = sync2_q;
        press_d = armed_q & ~sync2_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      fill_q  <= 2'b00;
      level_q <= 1'b1;
      cnt_q   <= 8'd0;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      fill_q  <= fill_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/gcd_operand_loader.sv
// Builds an operand pair for the GCD core from four switch nibbles entered with push-buttons.
module gcd_operand_loader
  import gcd_pkg::*;
#(
  parameter int DB_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic [1:0] key,
  input  logic       out_ready,
  output logic       op_valid,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [2:0] nib_cnt
);

  localparam logic [2:0] LAST_SLOT = 3'(NIBBLES_PER_PAIR - 1);

  logic [1:0] press;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_key
      key_debounce #(
        .DB_CYCLES(DB_CYCLES)
      ) u_key_debounce (
        .clk  (clk),
        .rst_n(rst_n),
        .key_n(key[gi]),
        .press(press[gi])
      );
    end
  endgenerate

  gcd_state_e        state_q, state_d;
  logic [2:0]        nib_cnt_q, nib_cnt_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic              op_valid_q, op_valid_d;

  always_comb begin
    state_d    = state_q;
    nib_cnt_d  = nib_cnt_q;
    pair_d     = pair_q;
    op_valid_d = op_valid_q;
    case (state_q)
      COLLECT: begin
        if (press[0]) begin
          pair_d    = insert_nibble(pair_q, nib_cnt_q[1:0], sw);
          nib_cnt_d = nib_cnt_q + 3'd1;
          if (nib_cnt_q == LAST_SLOT) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (press[1]) begin
          state_d    = OFFER;
          op_valid_d = 1'b1;
        end
      end
      OFFER: begin
        // Operands keep their values after the handshake; the next pair overwrites them slot by slot.
        if (op_valid_q && out_ready) begin
          state_d    = COLLECT;
          nib_cnt_d  = 3'd0;
          op_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = COLLECT;
        nib_cnt_d  = 3'd0;
        op_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      nib_cnt_q  <= 3'd0;
      pair_q     <= '0;
      op_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nib_cnt_q  <= nib_cnt_d;
      pair_q     <= pair_d;
      op_valid_q <= op_valid_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = pair_q[PAIR_W-1:OPERAND_W];
  assign op_b     = pair_q[OPERAND_W-1:0];
  assign nib_cnt  = nib_cnt_q;

endmodule

// File: tb/tb_gcd_operand_loader.sv
// Directed bench for gcd_operand_loader with a handshake scoreboard.
module tb_gcd_operand_loader;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sw = 4'h0;
  logic [1:0] key = 2'b11;
  logic       out_ready = 1'b0;
  logic       op_valid;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [2:0] nib_cnt;

  int checks = 0;
  int errors = 0;
  int valid_cycles = 0;
  int vc0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        unstable;

  gcd_operand_loader #(
    .DB_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw       (sw),
    .key      (key),
    .out_ready(out_ready),
    .op_valid (op_valid),
    .op_a     (op_a),
    .op_b     (op_b),
    .nib_cnt  (nib_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int b, input logic [3:0] v);
    sw = v;
    key[b] = 1'b0;
    tick(DB + 4);
    key[b] = 1'b1;
    tick(DB + 4);
  endtask

  // Scoreboard monitor: every accepted handshake must match the next queued pair.
  always @(negedge clk) begin
    if (rst_n && op_valid) valid_cycles++;
    if (rst_n && op_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL handshake: got pair %h%h expected none", op_a, op_b);
      end else begin
        mon_exp = exp_q.pop_front();
        $display("handshake op_a=%h op_b=%h", op_a, op_b);
        check("handshake_pair", {op_a, op_b}, mon_exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(3);
    check("rst_valid", 16'(op_valid), 16'h0);
    check("rst_op_a", 16'(op_a), 16'h0);
    check("rst_op_b", 16'(op_b), 16'h0);
    check("rst_nib", 16'(nib_cnt), 16'h0);
    rst_n = 1'b1;
    tick(4);

    // Basic pair 0x0F / 0x19 with out_ready already high
    out_ready = 1'b1;
    press_key(0, 4'h0); check("t1_nib1", 16'(nib_cnt), 16'd1);
    press_key(0, 4'hF); check("t1_nib2", 16'(nib_cnt), 16'd2);
    press_key(0, 4'h1); check("t1_nib3", 16'(nib_cnt), 16'd3);
    press_key(0, 4'h9); check("t1_nib4", 16'(nib_cnt), 16'd4);
    check("t1_pre_valid", 16'(op_valid), 16'h0);
    check("t1_op_a", 16'(op_a), 16'h0F);
    check("t1_op_b", 16'(op_b), 16'h19);
    vc0 = valid_cycles;
    exp_q.push_back(16'h0F19);
    press_key(1, 4'h0);
    check("t1_valid_cycles", 16'(valid_cycles - vc0), 16'd1);
    check("t1_post_valid", 16'(op_valid), 16'h0);
    check("t1_post_nib", 16'(nib_cnt), 16'd0);
    check("t1_keep_a", 16'(op_a), 16'h0F);

    // Early submit ignored; stale nibbles visible
    out_ready = 1'b0;
    press_key(0, 4'hA);
    check("t2_stale", {op_a, op_b}, 16'hAF19);
    press_key(0, 4'h5);
    press_key(1, 4'h0);
    check("t2_early_nib", 16'(nib_cnt), 16'd2);
    check("t2_early_valid", 16'(op_valid), 16'h0);
    press_key(0, 4'h3);
    press_key(0, 4'hC);
    check("t2_full_nib", 16'(nib_cnt), 16'd4);
    exp_q.push_back(16'hA53C);
    press_key(1, 4'h0);
    check("t2_valid", 16'(op_valid), 16'h1);
    out_ready = 1'b1;
    tick(2);
    check("t2_done_valid", 16'(op_valid), 16'h0);
    check("t2_done_nib", 16'(nib_cnt), 16'd0);

    // Stall in OFFER with presses and switch activity
    out_ready = 1'b0;
    press_key(0, 4'h1);
    press_key(0, 4'h2);
    press_key(0, 4'h3);
    press_key(0, 4'h4);
    exp_q.push_back(16'h1234);
    press_key(1, 4'h0);
    unstable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sw = 4'(i * 7);
      key[0] = ((i % 10) < 6) ? 1'b0 : 1'b1;
      tick(1);
      if (op_valid !== 1'b1 || {op_a, op_b} !== 16'h1234 || nib_cnt !== 3'd4) unstable = 1'b1;
    end
    check("t3_stable", 16'(unstable), 16'h0);
    key[0] = 1'b1;
    tick(DB + 4);
    check("t3_hold_pair", {op_a, op_b}, 16'h1234);
    vc0 = valid_cycles;
    out_ready = 1'b1;
    tick(2);
    check("t3_one_hs", 16'(valid_cycles - vc0), 16'd1);
    check("t3_nib", 16'(nib_cnt), 16'd0);
    check("t3_valid", 16'(op_valid), 16'h0);

    // Debounce boundaries
    out_ready = 1'b0;
    sw = 4'h5;
    key[0] = 1'b0; tick(3); key[0] = 1'b1; tick(10);
    check("t4_short3", 16'(nib_cnt), 16'd0);
    key[0] = 1'b0; tick(1); key[0] = 1'b1; tick(10);
    check("t4_glitch", 16'(nib_cnt), 16'd0);
    key[0] = 1'b0; tick(3); key[0] = 1'b1; tick(1); key[0] = 1'b0; tick(3); key[0] = 1'b1; tick(10);
    check("t4_split", 16'(nib_cnt), 16'd0);
    sw = 4'hE;
    key[0] = 1'b0;
    tick(DB + 2);
    check("t4_edge_k5", 16'(nib_cnt), 16'd0);
    tick(1);
    check("t4_edge_k6", 16'(nib_cnt), 16'd1);
    check("t4_capture", 16'(op_a[7:4]), 16'hE);
    key[0] = 1'b1;
    tick(DB + 4);
    sw = 4'h7;
    key[0] = 1'b0; tick(30); key[0] = 1'b1; tick(DB + 4);
    check("t4_long_hold", 16'(nib_cnt), 16'd2);
    check("t4_long_a", 16'(op_a), 16'hE7);

    // Reset during OFFER with key[0] held
    press_key(0, 4'h8);
    press_key(0, 4'h9);
    press_key(1, 4'h0);
    check("t5_offer", 16'(op_valid), 16'h1);
    key[0] = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check("t5_valid", 16'(op_valid), 16'h0);
    check("t5_pair", {op_a, op_b}, 16'h0000);
    check("t5_nib", 16'(nib_cnt), 16'd0);
    tick(20);
    check("t5_held", 16'(nib_cnt), 16'd0);
    key[0] = 1'b1;
    tick(DB + 4);
    check("t5_release", 16'(nib_cnt), 16'd0);
    press_key(0, 4'h6);
    check("t5_repress_nib", 16'(nib_cnt), 16'd1);
    check("t5_repress_a", 16'(op_a), 16'h60);

    tick(4);
    check("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
